// File: rtl/eth_pkg.sv
// Shared types for the Ethernet ingress path: FIFO word layout and framer states.
package eth_pkg;
  localparam int ETH_WORD_W = 34;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PKT     = 2'd1,
    DISCARD = 2'd2
  } eth_ing_state_e;
endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating event counter: +1 per cycle i_inc is high, holds at all-ones.
// Registered output, no backpressure; synchronous active-low reset clears it.
module eth_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/eth_ingress_framer.sv
// Ingress framer: validates framing, caps packet length, drops at SOP when the FIFO lacks room; 2-cycle latency.
// No backpressure (drops instead of stalling). Define ETH_ING_STATS_EN to add pktCnt/dropCnt/truncCnt.
module eth_ingress_framer
  import eth_pkg::*;
#(
  parameter int MAX_WORDS  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [31:0]                   inData,
  input  logic                          inSop,
  input  logic                          inEop,
  input  logic [$clog2(FIFO_DEPTH):0]   fifoFree,
  output logic                          outWrEn,
  output logic [ETH_WORD_W-1:0]         outData,
  output logic                          dropPulse,
  output logic                          truncPulse
`ifdef ETH_ING_STATS_EN
  ,
  output logic [CNT_W-1:0]              pktCnt,
  output logic [CNT_W-1:0]              dropCnt,
  output logic [CNT_W-1:0]              truncCnt
`endif
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MAX_WORDS + 1);
  // Room for a full packet plus the two words of the previous packet still in the pipe.
  localparam logic [FW-1:0] FREE_MIN = FW'(MAX_WORDS + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WORDS);

  if (MAX_WORDS < 2 || MAX_WORDS > FIFO_DEPTH - 2 || CNT_W < 1) begin : g_bad_cfg
    $error("eth_ingress_framer: illegal parameter combination");
  end

  eth_ing_state_e r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_s1_vld, w_s1_vld_nxt;
  eth_word_t      r_s1, w_s1_nxt, w_out_word;
  logic           w_new_sop, w_force_eop, w_drop, w_trunc;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_s1_vld_nxt = 1'b0;
    w_s1_nxt     = '{eop: inEop, sop: 1'b0, data: inData};
    w_new_sop    = 1'b0;
    w_force_eop  = 1'b0;
    w_drop       = 1'b0;
    w_trunc      = 1'b0;

    case (r_state)
      IDLE: w_new_sop = inSop;
      PKT: begin
        if (inSop) begin
          // Previous packet never saw EOP: close it on the word already in stage 1.
          w_force_eop = 1'b1;
          w_trunc     = 1'b1;
          w_new_sop   = 1'b1;
        end else begin
          w_s1_vld_nxt = 1'b1;
          w_cnt_nxt    = r_cnt + 1'b1;
          if (inEop) begin
            w_state_nxt = IDLE;
          end else if (w_cnt_nxt == CNT_MAX) begin
            w_s1_nxt.eop = 1'b1;
            w_trunc      = 1'b1;
            w_state_nxt  = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (inSop) begin
          w_new_sop = 1'b1;
        end else if (inEop) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_new_sop) begin
      if (inEop) begin
        w_drop      = 1'b1;
        w_state_nxt = IDLE;
      end else if (fifoFree < FREE_MIN) begin
        w_drop      = 1'b1;
        w_state_nxt = DISCARD;
      end else begin
        w_s1_vld_nxt = 1'b1;
        w_s1_nxt.sop = 1'b1;
        w_cnt_nxt    = CW'(1);
        w_state_nxt  = PKT;
      end
    end
  end

  always_comb begin
    w_out_word     = r_s1;
    w_out_word.eop = r_s1.eop | w_force_eop;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1       <= '0;
      outWrEn    <= 1'b0;
      outData    <= '0;
      dropPulse  <= 1'b0;
      truncPulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s1_vld   <= w_s1_vld_nxt;
      r_s1       <= w_s1_nxt;
      outWrEn    <= r_s1_vld;
      if (r_s1_vld) begin
        outData <= w_out_word;
      end
      dropPulse  <= w_drop;
      truncPulse <= w_trunc;
    end
  end

`ifdef ETH_ING_STATS_EN
  eth_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk    (clk),
    .resetN (resetN),
    .i_inc  (outWrEn & outData[ETH_WORD_W-1]),
    .o_cnt  (pktCnt)
  );

  eth_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk    (clk),
    .resetN (resetN),
    .i_inc  (dropPulse),
    .o_cnt  (dropCnt)
  );

  eth_sat_cnt #(.W(CNT_W)) u_trunc_cnt (
    .clk    (clk),
    .resetN (resetN),
    .i_inc  (truncPulse),
    .o_cnt  (truncCnt)
  );
`endif
endmodule
